llc_output_encoder: RTL and testbench

- Outbound counterpart of the LLC input decoder. It accepts messages emitted by the LLC pipeline on four output channels: rsp_out, fwd_out, mem_req and dma_rsp_out.
- Each channel is buffered in a small per-channel FIFO and drained over an independent valid/ready handshake toward the NoC/memory interface.
- Back-pressure to the pipeline is atomic: a cycle's sends are accepted all together or not at all.
- It reports an idle indication, which the flush/reset resume logic uses to detect drain completion.

---
 rtl/llc_output_encoder_pkg.sv | 29 ++
 rtl/llc_out_fifo.sv | 53 +++++
 rtl/llc_output_encoder.sv | 98 +++++++++
 tb/tb_llc_output_encoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/llc_output_encoder_pkg.sv
// Shared constants and types for the LLC output encoder: FIFO depth, channel indices,
// payload types and the saturating counter helper used by the LLC_OUT_PERF_EN counters.
package llc_output_encoder_pkg;

    localparam int LLC_OUT_DEPTH = 2;
    localparam int LLC_RSP_W     = 64;
    localparam int LLC_FWD_W     = 64;
    localparam int LLC_MEM_W     = 128;
    localparam int LLC_DMA_W     = 128;
    localparam int LLC_OUT_NCH   = 4;

    typedef enum logic [1:0] {
        CH_RSP = 2'd0,
        CH_FWD = 2'd1,
        CH_MEM = 2'd2,
        CH_DMA = 2'd3
    } llc_out_ch_e;

    typedef logic [LLC_RSP_W-1:0] llc_rsp_pl_t;
    typedef logic [LLC_FWD_W-1:0] llc_fwd_pl_t;
    typedef logic [LLC_MEM_W-1:0] llc_mem_pl_t;
    typedef logic [LLC_DMA_W-1:0] llc_dma_pl_t;

    // Counters stick at all-ones instead of wrapping back to a misleading small value.
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/llc_out_fifo.sv
// Per-channel output FIFO: registered occupancy, head always read from storage
// (no write-to-read bypass), so a push becomes visible one cycle later at the earliest.
module llc_out_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign valid = !empty;
    assign pop   = valid & ready;
    assign rdata = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/llc_output_encoder.sv
// LLC outbound encoder: four buffered channels with all-or-nothing acceptance of a cycle's sends.
// Optional performance counters are built when LLC_OUT_PERF_EN is defined.
module llc_output_encoder
    import llc_output_encoder_pkg::*;
#(
    parameter int DEPTH = LLC_OUT_DEPTH,
    parameter int RSP_W = LLC_RSP_W,
    parameter int FWD_W = LLC_FWD_W,
    parameter int MEM_W = LLC_MEM_W,
    parameter int DMA_W = LLC_DMA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send_rsp_out,
    input  logic             send_fwd_out,
    input  logic             send_mem_req,
    input  logic             send_dma_rsp_out,
    input  logic [RSP_W-1:0] rsp_out_pl_in,
    input  logic [FWD_W-1:0] fwd_out_pl_in,
    input  logic [MEM_W-1:0] mem_req_pl_in,
    input  logic [DMA_W-1:0] dma_rsp_pl_in,
    output logic             send_accept,
    output logic             llc_rsp_out_valid,
    output logic             llc_fwd_out_valid,
    output logic             llc_mem_req_valid,
    output logic             llc_dma_rsp_out_valid,
    input  logic             llc_rsp_out_ready,
    input  logic             llc_fwd_out_ready,
    input  logic             llc_mem_req_ready,
    input  logic             llc_dma_rsp_out_ready,
    output logic [RSP_W-1:0] llc_rsp_out_data,
    output logic [FWD_W-1:0] llc_fwd_out_data,
    output logic [MEM_W-1:0] llc_mem_req_data,
    output logic [DMA_W-1:0] llc_dma_rsp_out_data,
    output logic             out_idle
`ifdef LLC_OUT_PERF_EN
    ,
    input  logic             perf_clr,
    output logic [15:0]      perf_stall_cnt,
    output logic [15:0]      perf_bp_cnt [LLC_OUT_NCH]
`endif
);

    logic [LLC_OUT_NCH-1:0] send;
    logic [LLC_OUT_NCH-1:0] push;
    logic [LLC_OUT_NCH-1:0] full;
    logic [LLC_OUT_NCH-1:0] empty;
    logic [LLC_OUT_NCH-1:0] valid;
    logic [LLC_OUT_NCH-1:0] ready;

    assign send  = {send_dma_rsp_out, send_mem_req, send_fwd_out, send_rsp_out};
    assign ready = {llc_dma_rsp_out_ready, llc_mem_req_ready, llc_fwd_out_ready, llc_rsp_out_ready};
    assign valid = {llc_dma_rsp_out_valid, llc_mem_req_valid, llc_fwd_out_valid, llc_rsp_out_valid};

    // Only registered fullness gates acceptance, keeping ready off the send_accept path.
    assign send_accept = &(~send | ~full);
    assign push        = send & {LLC_OUT_NCH{send_accept}};
    assign out_idle    = &empty;

    llc_out_fifo #(.DEPTH(DEPTH), .W(RSP_W)) u_rsp_fifo (
        .clk(clk), .rst(rst), .push(push[CH_RSP]), .wdata(rsp_out_pl_in),
        .ready(llc_rsp_out_ready), .valid(llc_rsp_out_valid), .rdata(llc_rsp_out_data),
        .full(full[CH_RSP]), .empty(empty[CH_RSP])
    );

    llc_out_fifo #(.DEPTH(DEPTH), .W(FWD_W)) u_fwd_fifo (
        .clk(clk), .rst(rst), .push(push[CH_FWD]), .wdata(fwd_out_pl_in),
        .ready(llc_fwd_out_ready), .valid(llc_fwd_out_valid), .rdata(llc_fwd_out_data),
        .full(full[CH_FWD]), .empty(empty[CH_FWD])
    );

    llc_out_fifo #(.DEPTH(DEPTH), .W(MEM_W)) u_mem_fifo (
        .clk(clk), .rst(rst), .push(push[CH_MEM]), .wdata(mem_req_pl_in),
        .ready(llc_mem_req_ready), .valid(llc_mem_req_valid), .rdata(llc_mem_req_data),
        .full(full[CH_MEM]), .empty(empty[CH_MEM])
    );

    llc_out_fifo #(.DEPTH(DEPTH), .W(DMA_W)) u_dma_fifo (
        .clk(clk), .rst(rst), .push(push[CH_DMA]), .wdata(dma_rsp_pl_in),
        .ready(llc_dma_rsp_out_ready), .valid(llc_dma_rsp_out_valid), .rdata(llc_dma_rsp_out_data),
        .full(full[CH_DMA]), .empty(empty[CH_DMA])
    );

`ifdef LLC_OUT_PERF_EN
    // Clear wins over increment so software sees a clean zero after perf_clr.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            perf_stall_cnt <= '0;
            for (int i = 0; i < LLC_OUT_NCH; i++) perf_bp_cnt[i] <= '0;
        end else begin
            perf_stall_cnt <= sat_inc(perf_stall_cnt, (|send) && !send_accept);
            for (int i = 0; i < LLC_OUT_NCH; i++)
                perf_bp_cnt[i] <= sat_inc(perf_bp_cnt[i], valid[i] && !ready[i]);
        end
    end
`endif

endmodule

// File: tb/tb_llc_output_encoder.sv
// Self-checking bench for llc_output_encoder: per-cycle vector table plus hand-written
// wrap-around, mid-operation reset and (with LLC_OUT_PERF_EN) counter sequences.
module tb_llc_output_encoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         send_rsp_out, send_fwd_out, send_mem_req, send_dma_rsp_out;
    logic [63:0]  rsp_out_pl_in, fwd_out_pl_in;
    logic [127:0] mem_req_pl_in, dma_rsp_pl_in;
    logic         send_accept;
    logic         llc_rsp_out_valid, llc_fwd_out_valid, llc_mem_req_valid, llc_dma_rsp_out_valid;
    logic         llc_rsp_out_ready, llc_fwd_out_ready, llc_mem_req_ready, llc_dma_rsp_out_ready;
    logic [63:0]  llc_rsp_out_data, llc_fwd_out_data;
    logic [127:0] llc_mem_req_data, llc_dma_rsp_out_data;
    logic         out_idle;
`ifdef LLC_OUT_PERF_EN
    logic         perf_clr;
    logic [15:0]  perf_stall_cnt;
    logic [15:0]  perf_bp_cnt [4];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    llc_output_encoder dut (
        .clk(clk), .rst(rst),
        .send_rsp_out(send_rsp_out), .send_fwd_out(send_fwd_out),
        .send_mem_req(send_mem_req), .send_dma_rsp_out(send_dma_rsp_out),
        .rsp_out_pl_in(rsp_out_pl_in), .fwd_out_pl_in(fwd_out_pl_in),
        .mem_req_pl_in(mem_req_pl_in), .dma_rsp_pl_in(dma_rsp_pl_in),
        .send_accept(send_accept),
        .llc_rsp_out_valid(llc_rsp_out_valid), .llc_fwd_out_valid(llc_fwd_out_valid),
        .llc_mem_req_valid(llc_mem_req_valid), .llc_dma_rsp_out_valid(llc_dma_rsp_out_valid),
        .llc_rsp_out_ready(llc_rsp_out_ready), .llc_fwd_out_ready(llc_fwd_out_ready),
        .llc_mem_req_ready(llc_mem_req_ready), .llc_dma_rsp_out_ready(llc_dma_rsp_out_ready),
        .llc_rsp_out_data(llc_rsp_out_data), .llc_fwd_out_data(llc_fwd_out_data),
        .llc_mem_req_data(llc_mem_req_data), .llc_dma_rsp_out_data(llc_dma_rsp_out_data),
        .out_idle(out_idle)
`ifdef LLC_OUT_PERF_EN
        , .perf_clr(perf_clr), .perf_stall_cnt(perf_stall_cnt), .perf_bp_cnt(perf_bp_cnt)
`endif
    );

    // One row per clock cycle; bit order {dma, mem, fwd, rsp}, exp_data bytes likewise.
    typedef struct {
        logic [3:0]  send;
        logic [7:0]  pl;
        logic [3:0]  ready;
        logic        exp_accept;
        logic [3:0]  exp_valid;
        logic        exp_idle;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(logic [3:0] s, logic [7:0] p, logic [3:0] r, logic a,
                                logic [3:0] v, logic i, logic [31:0] d);
        vec_t t;
        t.send = s; t.pl = p; t.ready = r; t.exp_accept = a;
        t.exp_valid = v; t.exp_idle = i; t.exp_data = d;
        return t;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] valid_vec();
        return {llc_dma_rsp_out_valid, llc_mem_req_valid, llc_fwd_out_valid, llc_rsp_out_valid};
    endfunction

    function automatic logic [127:0] data_of(int ch);
        case (ch)
            0:       return 128'(llc_rsp_out_data);
            1:       return 128'(llc_fwd_out_data);
            2:       return llc_mem_req_data;
            default: return llc_dma_rsp_out_data;
        endcase
    endfunction

    // Drive one cycle of inputs just after the rising edge.
    task automatic apply_stimulus(input logic [3:0] s, input logic [7:0] p, input logic [3:0] r);
        @(posedge clk);
        #1;
        {send_dma_rsp_out, send_mem_req, send_fwd_out, send_rsp_out} = s;
        rsp_out_pl_in = 64'(p);
        fwd_out_pl_in = 64'(p);
        mem_req_pl_in = 128'(p);
        dma_rsp_pl_in = 128'(p);
        {llc_dma_rsp_out_ready, llc_mem_req_ready, llc_fwd_out_ready, llc_rsp_out_ready} = r;
    endtask

    task automatic check_output(input int row, input vec_t v);
        @(negedge clk);
        check($sformatf("row%0d accept", row), 128'(send_accept), 128'(v.exp_accept));
        check($sformatf("row%0d valid", row), 128'(valid_vec()), 128'(v.exp_valid));
        check($sformatf("row%0d idle", row), 128'(out_idle), 128'(v.exp_idle));
        for (int c = 0; c < 4; c++)
            if (v.exp_valid[c])
                check($sformatf("row%0d data ch%0d", row, c), data_of(c), 128'(v.exp_data[c*8 +: 8]));
    endtask

    initial begin
        int push_i, pop_i;
        logic          prev_stall;
        logic [127:0]  prev_data;

        rst = 1'b1;
        {send_dma_rsp_out, send_mem_req, send_fwd_out, send_rsp_out} = '0;
        {llc_dma_rsp_out_ready, llc_mem_req_ready, llc_fwd_out_ready, llc_rsp_out_ready} = '1;
        rsp_out_pl_in = '0; fwd_out_pl_in = '0; mem_req_pl_in = '0; dma_rsp_pl_in = '0;
`ifdef LLC_OUT_PERF_EN
        perf_clr = 1'b0;
`endif

        vecs[0]  = mk(4'b0001, 8'hA5, 4'b1111, 1'b1, 4'b0000, 1'b1, 32'h0);
        vecs[1]  = mk(4'b0000, 8'h00, 4'b1111, 1'b1, 4'b0001, 1'b0, 32'h0000_00A5);
        vecs[2]  = mk(4'b0000, 8'h00, 4'b1111, 1'b1, 4'b0000, 1'b1, 32'h0);
        vecs[3]  = mk(4'b0010, 8'h01, 4'b1101, 1'b1, 4'b0000, 1'b1, 32'h0);
        vecs[4]  = mk(4'b0010, 8'h02, 4'b1101, 1'b1, 4'b0010, 1'b0, 32'h0000_0100);
        vecs[5]  = mk(4'b0011, 8'h03, 4'b1101, 1'b0, 4'b0010, 1'b0, 32'h0000_0100);
        vecs[6]  = mk(4'b0011, 8'h03, 4'b1111, 1'b0, 4'b0010, 1'b0, 32'h0000_0100);
        vecs[7]  = mk(4'b0011, 8'h03, 4'b1101, 1'b1, 4'b0010, 1'b0, 32'h0000_0200);
        vecs[8]  = mk(4'b0000, 8'h00, 4'b1101, 1'b1, 4'b0011, 1'b0, 32'h0000_0203);
        vecs[9]  = mk(4'b0000, 8'h00, 4'b1111, 1'b1, 4'b0010, 1'b0, 32'h0000_0200);
        vecs[10] = mk(4'b0000, 8'h00, 4'b1111, 1'b1, 4'b0010, 1'b0, 32'h0000_0300);
        vecs[11] = mk(4'b0000, 8'h00, 4'b1111, 1'b1, 4'b0000, 1'b1, 32'h0);
        vecs[12] = mk(4'b0100, 8'h10, 4'b1011, 1'b1, 4'b0000, 1'b1, 32'h0);
        vecs[13] = mk(4'b0100, 8'h11, 4'b1111, 1'b1, 4'b0100, 1'b0, 32'h0010_0000);
        vecs[14] = mk(4'b0000, 8'h00, 4'b1011, 1'b1, 4'b0100, 1'b0, 32'h0011_0000);
        vecs[15] = mk(4'b0000, 8'h00, 4'b1111, 1'b1, 4'b0100, 1'b0, 32'h0011_0000);
        vecs[16] = mk(4'b0000, 8'h00, 4'b1111, 1'b1, 4'b0000, 1'b1, 32'h0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset valid", 128'(valid_vec()), 128'(4'b0000));
        check("reset idle", 128'(out_idle), 128'(1'b1));
        check("reset accept", 128'(send_accept), 128'(1'b1));

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].send, vecs[i].pl, vecs[i].ready);
            check_output(i, vecs[i]);
        end

        // dma wrap-around with ready toggling; pops must come out 0..6 in order and stay stable while stalled.
        push_i = 0; pop_i = 0; prev_stall = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 60 && pop_i < 7; cyc++) begin
            apply_stimulus((push_i < 7) ? 4'b1000 : 4'b0000, 8'(push_i), {cyc[0], 3'b111});
            @(negedge clk);
            if (prev_stall) begin
                check("dma hold valid", 128'(llc_dma_rsp_out_valid), 128'(1'b1));
                check("dma hold data", llc_dma_rsp_out_data, prev_data);
            end
            if (send_dma_rsp_out && send_accept) push_i++;
            if (llc_dma_rsp_out_valid && llc_dma_rsp_out_ready) begin
                check($sformatf("dma order %0d", pop_i), llc_dma_rsp_out_data, 128'(pop_i));
                pop_i++;
            end
            prev_stall = llc_dma_rsp_out_valid && !llc_dma_rsp_out_ready;
            prev_data  = llc_dma_rsp_out_data;
        end
        check("dma pop count", 128'(pop_i), 128'(7));
        apply_stimulus(4'b0000, 8'h00, 4'b1111);
        @(negedge clk);
        check("dma drained idle", 128'(out_idle), 128'(1'b1));

        // Reset while messages are buffered drops them all.
        apply_stimulus(4'b0011, 8'h77, 4'b0000);
        apply_stimulus(4'b0000, 8'h00, 4'b0000);
        @(negedge clk);
        check("pre-reset valid", 128'(valid_vec()), 128'(4'b0011));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid reset valid", 128'(valid_vec()), 128'(4'b0000));
        check("mid reset idle", 128'(out_idle), 128'(1'b1));

`ifdef LLC_OUT_PERF_EN
        // rsp held full with ready low: 20 stalled cycles, 21 valid&!ready cycles.
        apply_stimulus(4'b0001, 8'h55, 4'b1110);
        perf_clr = 1'b1;
        apply_stimulus(4'b0001, 8'h56, 4'b1110);
        perf_clr = 1'b0;
        @(negedge clk);
        check("perf clr stall", 128'(perf_stall_cnt), 128'(0));
        check("perf clr bp", 128'(perf_bp_cnt[0]), 128'(0));
        for (int i = 0; i < 20; i++) apply_stimulus(4'b0001, 8'h57, 4'b1110);
        apply_stimulus(4'b0000, 8'h00, 4'b1110);
        @(negedge clk);
        check("perf stall", 128'(perf_stall_cnt), 128'(20));
        check("perf bp rsp", 128'(perf_bp_cnt[0]), 128'(21));
        check("perf bp fwd", 128'(perf_bp_cnt[1]), 128'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
